// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports (IF fetch, MEM data) and the single-ported
// memory bus of mem_arbiter.
//   slave  : arbiter view (requests and mem_rdata in; ready/rdata/stall and
//            memory strobes out)
//   master : environment view (pipeline requesters plus memory model)
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
    // instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    // data port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_stall;
    // memory side
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output if_rdata, if_ready, if_stall,
        output d_rdata, d_ready, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  if_rdata, if_ready, if_stall,
        input  d_rdata, d_ready, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one fixed-latency, single-ported memory between the IF (instruction)
// and MEM (data) ports. One access at a time: IDLE -> ISSUE -> WAIT -> DONE.
// D wins arbitration unless I has lost STARVE_MAX consecutive times.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : mem_arbiter_if.slave
//            if_req/if_addr -> if_rdata/if_ready/if_stall
//            d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready/d_stall
//            mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
// Parameters:
//   MEM_LATENCY : mem_en cycle to mem_rdata valid (1..15)
//   STARVE_MAX  : lost arbitrations before I is forced to win (1..7)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned STARVE_MAX  = 2
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAT_INIT  = 4'(MEM_LATENCY);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    logic [1:0]  r_state;
    logic        r_owner_d;      // 1 = data port owns the in-flight access
    logic        r_we;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic [2:0]  r_starve_cnt;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_if_ready;
    logic        r_d_ready;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_any_req;
    logic        w_grant_i;

    assign w_any_req = bus.if_req | bus.d_req;
    // I wins when D is absent or when I has been starved long enough.
    assign w_grant_i = bus.if_req & (~bus.d_req | (r_starve_cnt == STARVE_LIM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_starve_cnt <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_if_ready   <= 1'b0;
            r_d_ready    <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            // strobes default low; each is set for exactly one cycle below
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= S_ISSUE;
                        r_mem_en <= 1'b1;
                        r_cnt    <= LAT_INIT;
                        if (w_grant_i) begin
                            r_owner_d    <= 1'b0;
                            r_we         <= 1'b0;
                            r_addr       <= bus.if_addr[31:2];
                            r_wdata      <= '0;
                            r_starve_cnt <= '0;
                        end else begin
                            r_owner_d <= 1'b1;
                            r_we      <= bus.d_we;
                            r_mem_we  <= bus.d_we;
                            r_addr    <= bus.d_addr[31:2];
                            r_wdata   <= bus.d_wdata;
                            if (bus.if_req && (r_starve_cnt < STARVE_LIM))
                                r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        if (r_owner_d) begin
                            r_d_ready <= 1'b1;
                            if (!r_we)
                                r_d_rdata <= bus.mem_rdata;
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                default: begin
                    // S_DONE: ready pulse is visible this cycle; requests ignored
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.if_stall  = bus.if_req & ~r_if_ready;
    assign bus.d_stall   = bus.d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: u_dut0 (MEM_LATENCY=2, STARVE_MAX=2) and
// u_dut1 (MEM_LATENCY=1). "Cycle 0" is the clock period in which a request is
// first presented in IDLE; inputs are driven and outputs sampled 1ns after
// each rising edge.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if bus0 ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(2)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int unsigned exp_i [6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        int n_grant;
        int n_en;
        n_checks = 0;
        n_errors = 0;

        bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_addr = '0; bus0.d_wdata = '0; bus0.mem_rdata = '0;
        bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;

        reset = 1'b1;
        step(); step();
        // reset values
        check_val("rst_if_rdata",  bus0.if_rdata, 32'h0);
        check_val("rst_d_rdata",   bus0.d_rdata, 32'h0);
        check_val("rst_if_ready",  32'(bus0.if_ready), 32'h0);
        check_val("rst_d_ready",   32'(bus0.d_ready), 32'h0);
        check_val("rst_mem_en",    32'(bus0.mem_en), 32'h0);
        check_val("rst_mem_we",    32'(bus0.mem_we), 32'h0);
        check_val("rst_mem_addr",  32'(bus0.mem_addr), 32'h0);
        check_val("rst_mem_wdata", bus0.mem_wdata, 32'h0);
        check_val("rst_starve",    32'(u_dut0.r_starve_cnt), 32'h0);
        bus0.d_req = 1;
        #1 check_val("rst_d_stall_follows_req", 32'(bus0.d_stall), 32'h1);
        bus0.d_req = 0;
        reset = 1'b0;
        step();

        // ---- I read alone, latency 2 ----
        bus0.if_req = 1; bus0.if_addr = 32'h0000_0010; bus0.mem_rdata = 32'hBAD0_0000;
        #1 check_val("rd_c0_stall", 32'(bus0.if_stall), 32'h1);
        check_val("rd_c0_mem_en", 32'(bus0.mem_en), 32'h0);
        step(); // c1
        check_val("rd_c1_mem_en",   32'(bus0.mem_en), 32'h1);
        check_val("rd_c1_mem_addr", 32'(bus0.mem_addr), 32'h4);
        check_val("rd_c1_mem_we",   32'(bus0.mem_we), 32'h0);
        check_val("rd_c1_stall",    32'(bus0.if_stall), 32'h1);
        step(); // c2
        bus0.mem_rdata = 32'hBAD0_0002;
        check_val("rd_c2_mem_en", 32'(bus0.mem_en), 32'h0);
        check_val("rd_c2_stall",  32'(bus0.if_stall), 32'h1);
        step(); // c3
        bus0.mem_rdata = 32'h2002_0005;
        check_val("rd_c3_ready", 32'(bus0.if_ready), 32'h0);
        check_val("rd_c3_stall", 32'(bus0.if_stall), 32'h1);
        step(); // c4
        bus0.mem_rdata = 32'hBAD0_0004;
        check_val("rd_c4_ready", 32'(bus0.if_ready), 32'h1);
        check_val("rd_c4_rdata", bus0.if_rdata, 32'h2002_0005);
        check_val("rd_c4_stall", 32'(bus0.if_stall), 32'h0);
        bus0.if_req = 0;
        step(); // c5
        check_val("rd_c5_ready", 32'(bus0.if_ready), 32'h0);

        // ---- simultaneous I and D load ----
        bus0.if_req = 1; bus0.if_addr = 32'h0000_0100;
        bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h0000_0040;
        bus0.mem_rdata = 32'h0;
        step(); // c1
        check_val("both_c1_mem_en",   32'(bus0.mem_en), 32'h1);
        check_val("both_c1_mem_addr", 32'(bus0.mem_addr), 32'h10);
        step(); step(); // c3
        bus0.mem_rdata = 32'h1111_2222;
        step(); // c4
        bus0.mem_rdata = 32'h0;
        check_val("both_c4_d_ready",  32'(bus0.d_ready), 32'h1);
        check_val("both_c4_d_rdata",  bus0.d_rdata, 32'h1111_2222);
        check_val("both_c4_if_ready", 32'(bus0.if_ready), 32'h0);
        check_val("both_c4_if_stall", 32'(bus0.if_stall), 32'h1);
        bus0.d_req = 0;
        step(); // c5 IDLE
        check_val("both_c5_mem_en", 32'(bus0.mem_en), 32'h0);
        step(); // c6
        check_val("both_c6_mem_en",   32'(bus0.mem_en), 32'h1);
        check_val("both_c6_mem_addr", 32'(bus0.mem_addr), 32'h40);
        step(); step(); // c8
        bus0.mem_rdata = 32'h3333_4444;
        step(); // c9
        bus0.mem_rdata = 32'h0;
        check_val("both_c9_if_ready", 32'(bus0.if_ready), 32'h1);
        check_val("both_c9_if_rdata", bus0.if_rdata, 32'h3333_4444);
        check_val("both_c9_d_rdata",  bus0.d_rdata, 32'h1111_2222);
        bus0.if_req = 0;
        step();

        // ---- store ----
        bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h0000_0080; bus0.d_wdata = 32'hDEAD_BEEF;
        bus0.mem_rdata = 32'h5A5A_5A5A;
        n_en = 0;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (bus0.mem_en) n_en++;
            if (c == 1) begin
                check_val("st_c1_mem_we",    32'(bus0.mem_we), 32'h1);
                check_val("st_c1_mem_addr",  32'(bus0.mem_addr), 32'h20);
                check_val("st_c1_mem_wdata", bus0.mem_wdata, 32'hDEAD_BEEF);
                bus0.d_wdata = 32'h0; // late change must not reach memory
            end
            if (c == 2) begin
                check_val("st_c2_mem_we",    32'(bus0.mem_we), 32'h0);
                check_val("st_c2_mem_wdata", bus0.mem_wdata, 32'hDEAD_BEEF);
            end
        end
        check_val("st_mem_en_cycles", 32'(n_en), 32'h1);
        check_val("st_c4_d_ready",    32'(bus0.d_ready), 32'h1);
        check_val("st_c4_d_rdata",    bus0.d_rdata, 32'h1111_2222);
        bus0.d_req = 0; bus0.d_we = 0;
        step(); step();

        // ---- starvation: both held continuously ----
        bus0.if_req = 1; bus0.if_addr = 32'h0000_0200;
        bus0.d_req = 1;  bus0.d_addr = 32'h0000_0300;
        n_grant = 0;
        for (int c = 0; c < 60 && n_grant < 6; c++) begin
            step();
            if (bus0.mem_en) begin
                check_val($sformatf("starve_grant%0d_is_i", n_grant),
                          32'(bus0.mem_addr == 30'h80), 32'(exp_i[n_grant]));
                if (exp_i[n_grant] == 1)
                    check_val($sformatf("starve_cnt_after_i%0d", n_grant),
                              32'(u_dut0.r_starve_cnt), 32'h0);
                n_grant++;
            end
        end
        check_val("starve_grants_seen", 32'(n_grant), 32'h6);
        bus0.if_req = 0; bus0.d_req = 0;
        for (int c = 0; c < 6; c++) step();

        // ---- reset during WAIT of a D load ----
        bus0.d_req = 1; bus0.d_addr = 32'h0000_0044; bus0.mem_rdata = 32'h0;
        step(); // c1
        check_val("rw_c1_mem_en", 32'(bus0.mem_en), 32'h1);
        step(); // c2 WAIT
        reset = 1'b1;
        #1;
        check_val("rw_mem_en",   32'(bus0.mem_en), 32'h0);
        check_val("rw_mem_addr", 32'(bus0.mem_addr), 32'h0);
        check_val("rw_d_rdata",  bus0.d_rdata, 32'h0);
        check_val("rw_d_ready",  32'(bus0.d_ready), 32'h0);
        n_en = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus0.d_ready) n_en++;
        end
        check_val("rw_no_ready_in_reset", 32'(n_en), 32'h0);
        reset = 1'b0; // this period is cycle 0 with d_req held
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) check_val("rw_reissue_addr", 32'(bus0.mem_addr), 32'h11);
            if (c == 1) check_val("rw_reissue_en",   32'(bus0.mem_en), 32'h1);
            if (c == 3) begin
                check_val("rw_c3_d_ready", 32'(bus0.d_ready), 32'h0);
                bus0.mem_rdata = 32'h5555_6666;
            end
        end
        bus0.mem_rdata = 32'h0;
        check_val("rw_c4_d_ready", 32'(bus0.d_ready), 32'h1);
        check_val("rw_c4_d_rdata", bus0.d_rdata, 32'h5555_6666);
        bus0.d_req = 0;
        step();

        // ---- latency 1 I read on u_dut1 ----
        bus1.if_req = 1; bus1.if_addr = 32'h0000_0024; bus1.mem_rdata = 32'h0;
        step(); // c1
        check_val("l1_c1_mem_en",   32'(bus1.mem_en), 32'h1);
        check_val("l1_c1_mem_addr", 32'(bus1.mem_addr), 32'h9);
        step(); // c2
        bus1.mem_rdata = 32'h7777_8888;
        check_val("l1_c2_ready", 32'(bus1.if_ready), 32'h0);
        step(); // c3
        bus1.mem_rdata = 32'h9999_0000;
        check_val("l1_c3_ready", 32'(bus1.if_ready), 32'h1);
        check_val("l1_c3_rdata", bus1.if_rdata, 32'h7777_8888);
        bus1.if_req = 0;
        step(); // c4
        check_val("l1_c4_ready", 32'(bus1.if_ready), 32'h0);
        check_val("l1_c4_rdata", bus1.if_rdata, 32'h7777_8888);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
